// File: rtl/mfcc_frame_scheduler_if.sv
// Control/status bundle between the MFCC frame scheduler (slave) and the block driving it (master).
interface mfcc_frame_scheduler_if #(
  parameter int FRAME_CNT_W = 16
);
  logic                   enable_i;
  logic                   continuous_i;
  logic [FRAME_CNT_W-1:0] num_frames_i;
  logic                   frame_ready_i;
  logic                   win_idle_i;
  logic                   hamming_done_i;
  logic                   fft_ready_i;
  logic                   hamming_start_o;
  logic                   fft_start_o;
  logic                   move_o;
  logic [FRAME_CNT_W-1:0] frame_idx_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   error_o;

  modport master (
    output enable_i, continuous_i, num_frames_i, frame_ready_i, win_idle_i, hamming_done_i, fft_ready_i,
    input  hamming_start_o, fft_start_o, move_o, frame_idx_o, busy_o, done_o, error_o
  );

  modport slave (
    input  enable_i, continuous_i, num_frames_i, frame_ready_i, win_idle_i, hamming_done_i, fft_ready_i,
    output hamming_start_o, fft_start_o, move_o, frame_idx_o, busy_o, done_o, error_o
  );
endinterface

// File: rtl/mfcc_frame_scheduler.sv
// MFCC frame sequencer: window full -> Hamming -> FFT handshake (held until accepted) -> window move; 1-cycle registered latency per step.
// FRAME_SCHED_TIMEOUT_EN adds a RUN_HAMMING watchdog driving a sticky error_o; otherwise error_o is tied low.
module mfcc_frame_scheduler #(
  parameter int FRAME_CNT_W = 16
`ifdef FRAME_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  mfcc_frame_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_RUN_HAMMING,
    S_WAIT_FFT,
    S_MOVE,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic                   r_pending;
  logic [FRAME_CNT_W-1:0] r_num_frames;
  logic [FRAME_CNT_W-1:0] r_frame_idx;
  logic                   r_ham_start;
  logic                   r_fft_start;
  logic                   r_move;
  logic                   r_busy;
  logic                   r_done;

  logic [FRAME_CNT_W-1:0] w_idx_nxt;
  logic                   w_last;

`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_error;
`endif

  assign w_idx_nxt = r_frame_idx + FRAME_CNT_W'(1);
  assign w_last    = !bus.continuous_i && (w_idx_nxt == r_num_frames);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pending    <= 1'b0;
      r_num_frames <= '0;
      r_frame_idx  <= '0;
      r_ham_start  <= 1'b0;
      r_fft_start  <= 1'b0;
      r_move       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef FRAME_SCHED_TIMEOUT_EN
      r_tmo_cnt    <= '0;
      r_error      <= 1'b0;
`endif
    end else begin
      r_ham_start <= 1'b0;
      r_move      <= 1'b0;
      r_done      <= 1'b0;

      // Early window-ready pulses are remembered; the WAIT_FRAME consume below overrides this set.
      if (bus.frame_ready_i && ((r_state != S_IDLE) || bus.enable_i))
        r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (bus.enable_i) begin
            r_busy <= 1'b1;
            if (!bus.continuous_i && (bus.num_frames_i == '0)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= S_WAIT_FRAME;
              r_num_frames <= bus.num_frames_i;
              r_frame_idx  <= '0;
`ifdef FRAME_SCHED_TIMEOUT_EN
              r_error      <= 1'b0;
`endif
            end
          end
        end

        S_WAIT_FRAME: begin
          if (!bus.enable_i) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
          end else if (r_pending || bus.frame_ready_i) begin
            r_state     <= S_RUN_HAMMING;
            r_ham_start <= 1'b1;
            r_pending   <= 1'b0;
`ifdef FRAME_SCHED_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
          end
        end

        S_RUN_HAMMING: begin
          if (bus.hamming_done_i) begin
            r_state     <= S_WAIT_FFT;
            r_fft_start <= 1'b1;
          end
`ifdef FRAME_SCHED_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            r_state <= S_IDLE;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
`endif
        end

        S_WAIT_FFT: begin
          if (r_fft_start && bus.fft_ready_i) begin
            r_state     <= S_MOVE;
            r_fft_start <= 1'b0;
          end
        end

        S_MOVE: begin
          if (bus.win_idle_i) begin
            r_move <= 1'b1;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_WAIT_FRAME;
              r_frame_idx <= w_idx_nxt;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_fft_start <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hamming_start_o = r_ham_start;
  assign bus.fft_start_o     = r_fft_start;
  assign bus.move_o          = r_move;
  assign bus.frame_idx_o     = r_frame_idx;
  assign bus.busy_o          = r_busy;
  assign bus.done_o          = r_done;
`ifdef FRAME_SCHED_TIMEOUT_EN
  assign bus.error_o         = r_error;
`else
  assign bus.error_o         = 1'b0;
`endif

endmodule

// File: tb/tb_mfcc_frame_scheduler.sv
// Directed bench for mfcc_frame_scheduler; the watchdog section runs only with FRAME_SCHED_TIMEOUT_EN.
module tb_mfcc_frame_scheduler;
  localparam int FW = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_hs = 0, n_hsk = 0, n_mv = 0, n_dn = 0;

  mfcc_frame_scheduler_if #(.FRAME_CNT_W(FW)) bus ();

`ifdef FRAME_SCHED_TIMEOUT_EN
  mfcc_frame_scheduler #(.FRAME_CNT_W(FW), .TIMEOUT_CYCLES(100)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  mfcc_frame_scheduler #(.FRAME_CNT_W(FW)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  // Pulse/handshake tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.hamming_start_o) n_hs++;
    if (bus.fft_start_o && bus.fft_ready_i) n_hsk++;
    if (bus.move_o) n_mv++;
    if (bus.done_o) n_dn++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, observed hang expected completion");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk_b({tag, ".ham_start"}, bus.hamming_start_o, 1'b0);
    chk_b({tag, ".fft_start"}, bus.fft_start_o, 1'b0);
    chk_b({tag, ".move"}, bus.move_o, 1'b0);
    chk_b({tag, ".done"}, bus.done_o, 1'b0);
    chk_b({tag, ".busy"}, bus.busy_o, 1'b0);
    chk_b({tag, ".error"}, bus.error_o, 1'b0);
    chk_i({tag, ".idx"}, int'(bus.frame_idx_o), 0);
  endtask

  // Expects WAIT_FRAME with fft_ready_i=1 and win_idle_i=1; returns just after move_o rises.
  task automatic do_frame(input int idx, input int ham_wait, input bit drop_en);
    bus.frame_ready_i = 1'b1;
    tick();
    bus.frame_ready_i = 1'b0;
    chk_b("ham_start_latency", bus.hamming_start_o, 1'b1);
    chk_i("idx_at_start", int'(bus.frame_idx_o), idx);
    if (drop_en) bus.enable_i = 1'b0;
    tick();
    chk_b("ham_start_one_cycle", bus.hamming_start_o, 1'b0);
    repeat (ham_wait) tick();
    bus.hamming_done_i = 1'b1;
    tick();
    bus.hamming_done_i = 1'b0;
    chk_b("fft_start_latency", bus.fft_start_o, 1'b1);
    tick();
    chk_b("fft_start_drop", bus.fft_start_o, 1'b0);
    tick();
    chk_b("move_latency", bus.move_o, 1'b1);
  endtask

  initial begin
    int b_hs, b_hsk, b_mv, b_dn, cnt;

    rst = 1'b1;
    bus.enable_i       = 1'b0;
    bus.continuous_i   = 1'b0;
    bus.num_frames_i   = '0;
    bus.frame_ready_i  = 1'b0;
    bus.win_idle_i     = 1'b0;
    bus.hamming_done_i = 1'b0;
    bus.fft_ready_i    = 1'b0;
    repeat (2) tick();
    chk_quiet("reset");
    rst = 1'b0;
    tick();
    chk_quiet("after_reset");

    // Three programmed frames, Hamming takes 400 cycles each.
    b_hs = n_hs; b_hsk = n_hsk; b_mv = n_mv; b_dn = n_dn;
    bus.num_frames_i = 16'd3;
    bus.fft_ready_i  = 1'b1;
    bus.win_idle_i   = 1'b1;
    bus.enable_i     = 1'b1;
    tick();
    chk_b("run3.busy", bus.busy_o, 1'b1);
    do_frame(0, 398, 1'b0);
    chk_i("run3.idx_after_f0", int'(bus.frame_idx_o), 1);
    chk_b("run3.no_done_f0", bus.done_o, 1'b0);
    do_frame(1, 398, 1'b0);
    chk_i("run3.idx_after_f1", int'(bus.frame_idx_o), 2);
    do_frame(2, 398, 1'b0);
    chk_b("run3.done", bus.done_o, 1'b1);
    chk_i("run3.idx_final", int'(bus.frame_idx_o), 2);
    bus.enable_i = 1'b0;
    tick();
    chk_b("run3.done_one_cycle", bus.done_o, 1'b0);
    chk_b("run3.idle", bus.busy_o, 1'b0);
    chk_i("run3.n_ham_start", n_hs - b_hs, 3);
    chk_i("run3.n_fft_hs", n_hsk - b_hsk, 3);
    chk_i("run3.n_move", n_mv - b_mv, 3);
    chk_i("run3.n_done", n_dn - b_dn, 1);

    // FFT backpressure for 50 cycles on a single-frame run.
    b_hs = n_hs; b_mv = n_mv; b_hsk = n_hsk;
    bus.num_frames_i = 16'd1;
    bus.fft_ready_i  = 1'b0;
    bus.enable_i     = 1'b1;
    tick();
    bus.frame_ready_i = 1'b1;
    tick();
    bus.frame_ready_i = 1'b0;
    chk_b("bp.ham_start", bus.hamming_start_o, 1'b1);
    repeat (3) tick();
    bus.hamming_done_i = 1'b1;
    tick();
    bus.hamming_done_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.fft_start_o) cnt++;
      tick();
    end
    chk_i("bp.fft_start_held", cnt, 50);
    chk_b("bp.fft_start_still", bus.fft_start_o, 1'b1);
    chk_i("bp.no_move", n_mv - b_mv, 0);
    bus.fft_ready_i = 1'b1;
    tick();
    chk_b("bp.fft_start_drop", bus.fft_start_o, 1'b0);
    tick();
    chk_b("bp.move", bus.move_o, 1'b1);
    chk_b("bp.done", bus.done_o, 1'b1);
    chk_i("bp.idx", int'(bus.frame_idx_o), 0);
    bus.enable_i = 1'b0;
    tick();
    chk_b("bp.idle", bus.busy_o, 1'b0);
    chk_i("bp.n_ham_start", n_hs - b_hs, 1);
    chk_i("bp.n_fft_hs", n_hsk - b_hsk, 1);

    // Two frame_ready pulses during WAIT_FFT collapse into one pending start.
    b_hs = n_hs;
    bus.num_frames_i = 16'd2;
    bus.fft_ready_i  = 1'b0;
    bus.enable_i     = 1'b1;
    tick();
    bus.frame_ready_i = 1'b1;
    tick();
    bus.frame_ready_i = 1'b0;
    tick();
    bus.hamming_done_i = 1'b1;
    tick();
    bus.hamming_done_i = 1'b0;
    chk_b("early.fft_start", bus.fft_start_o, 1'b1);
    bus.frame_ready_i = 1'b1;
    tick();
    bus.frame_ready_i = 1'b0;
    tick();
    bus.frame_ready_i = 1'b1;
    tick();
    bus.frame_ready_i = 1'b0;
    chk_b("early.no_restart", bus.hamming_start_o, 1'b0);
    bus.fft_ready_i = 1'b1;
    tick();
    tick();
    chk_b("early.move", bus.move_o, 1'b1);
    chk_i("early.idx", int'(bus.frame_idx_o), 1);
    tick();
    chk_b("early.pending_start", bus.hamming_start_o, 1'b1);
    tick();
    bus.hamming_done_i = 1'b1;
    tick();
    bus.hamming_done_i = 1'b0;
    tick();
    tick();
    chk_b("early.move2", bus.move_o, 1'b1);
    chk_b("early.done", bus.done_o, 1'b1);
    bus.enable_i = 1'b0;
    tick();
    chk_i("early.n_ham_start", n_hs - b_hs, 2);
    chk_b("early.idle", bus.busy_o, 1'b0);

    // Zero frames programmed: straight to DONE.
    b_hs = n_hs; b_dn = n_dn;
    bus.num_frames_i = 16'd0;
    bus.enable_i     = 1'b1;
    tick();
    chk_b("zero.done", bus.done_o, 1'b1);
    chk_b("zero.busy", bus.busy_o, 1'b1);
    bus.enable_i = 1'b0;
    tick();
    chk_b("zero.done_one_cycle", bus.done_o, 1'b0);
    chk_b("zero.idle", bus.busy_o, 1'b0);
    chk_i("zero.n_ham_start", n_hs - b_hs, 0);
    chk_i("zero.n_done", n_dn - b_dn, 1);

    // Continuous mode, 10 frames, enable dropped during the last one.
    b_hs = n_hs; b_mv = n_mv; b_dn = n_dn;
    bus.continuous_i = 1'b1;
    bus.enable_i     = 1'b1;
    tick();
    for (int f = 0; f < 9; f++) begin
      do_frame(f, 2, 1'b0);
      chk_i("cont.idx", int'(bus.frame_idx_o), f + 1);
    end
    do_frame(9, 2, 1'b1);
    chk_i("cont.idx_last", int'(bus.frame_idx_o), 10);
    chk_b("cont.busy_after_move", bus.busy_o, 1'b1);
    tick();
    chk_b("cont.idle", bus.busy_o, 1'b0);
    chk_i("cont.n_move", n_mv - b_mv, 10);
    chk_i("cont.n_ham_start", n_hs - b_hs, 10);
    chk_i("cont.n_done", n_dn - b_dn, 0);
    bus.continuous_i = 1'b0;

`ifdef FRAME_SCHED_TIMEOUT_EN
    b_mv = n_mv; b_dn = n_dn;
    bus.num_frames_i = 16'd1;
    bus.enable_i     = 1'b1;
    tick();
    bus.frame_ready_i = 1'b1;
    tick();
    bus.frame_ready_i = 1'b0;
    chk_b("tmo.ham_start", bus.hamming_start_o, 1'b1);
    repeat (99) tick();
    chk_b("tmo.no_error_yet", bus.error_o, 1'b0);
    chk_b("tmo.busy_yet", bus.busy_o, 1'b1);
    tick();
    bus.enable_i = 1'b0;
    chk_b("tmo.error", bus.error_o, 1'b1);
    chk_b("tmo.idle", bus.busy_o, 1'b0);
    chk_i("tmo.n_move", n_mv - b_mv, 0);
    tick();
    chk_b("tmo.sticky", bus.error_o, 1'b1);
    chk_i("tmo.n_done", n_dn - b_dn, 0);
    bus.enable_i = 1'b1;
    tick();
    chk_b("tmo.cleared_on_start", bus.error_o, 1'b0);
    bus.enable_i = 1'b0;
    tick();
`endif

    // Reset asserted while Hamming runs.
    b_mv = n_mv;
    bus.num_frames_i = 16'd5;
    bus.enable_i     = 1'b1;
    tick();
    bus.frame_ready_i = 1'b1;
    tick();
    bus.frame_ready_i = 1'b0;
    chk_b("rstmid.ham_start", bus.hamming_start_o, 1'b1);
    tick();
    chk_b("rstmid.busy", bus.busy_o, 1'b1);
    rst = 1'b1;
    bus.enable_i = 1'b0;
    #1;
    chk_quiet("rstmid.async");
    tick();
    chk_quiet("rstmid.next");
    rst = 1'b0;
    bus.hamming_done_i = 1'b1;
    tick();
    bus.hamming_done_i = 1'b0;
    tick();
    chk_quiet("rstmid.done_ignored");
    chk_i("rstmid.n_move", n_mv - b_mv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
